// File: rtl/prl_rx_event_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prl_rx_event_arb_if                                                        |
// | Source pulses, PE event channel and drop counter for prl_rx_event_arb.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface prl_rx_event_arb_if #(
  parameter int INFO_W = 49,
  parameter int DROP_W = 4
);
  logic              rx_evt_en;
  logic [2:0]        rx_evt_result;
  logic [6:0]        rx_evt_type;
  logic [2:0]        rx_evt_sop;
  logic [INFO_W-1:0] rx_evt_info;
  logic              tx_evt_en;
  logic [2:0]        tx_evt_result;
  logic [2:0]        tx_evt_sop;
  logic              hr_evt_en;
  logic [2:0]        hr_evt_sop;
  logic              pe_evt_valid;
  logic              pe_evt_ready;
  logic [1:0]        pe_evt_src;
  logic [2:0]        pe_evt_result;
  logic [6:0]        pe_evt_type;
  logic [2:0]        pe_evt_sop;
  logic [INFO_W-1:0] pe_evt_info;
  logic [DROP_W-1:0] drop_cnt;
  logic              drop_clr;
  logic              busy;

  modport master (
    output rx_evt_en, rx_evt_result, rx_evt_type, rx_evt_sop, rx_evt_info,
    output tx_evt_en, tx_evt_result, tx_evt_sop,
    output hr_evt_en, hr_evt_sop,
    output pe_evt_ready, drop_clr,
    input  pe_evt_valid, pe_evt_src, pe_evt_result, pe_evt_type, pe_evt_sop,
    input  pe_evt_info, drop_cnt, busy
  );

  modport slave (
    input  rx_evt_en, rx_evt_result, rx_evt_type, rx_evt_sop, rx_evt_info,
    input  tx_evt_en, tx_evt_result, tx_evt_sop,
    input  hr_evt_en, hr_evt_sop,
    input  pe_evt_ready, drop_clr,
    output pe_evt_valid, pe_evt_src, pe_evt_result, pe_evt_type, pe_evt_sop,
    output pe_evt_info, drop_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/prl_rx_event_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prl_rx_event_arb                                                           |
// | Arbitrates RX/TX/hard-reset events onto a back-pressured PE event channel. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prl_rx_event_arb #(
  parameter int INFO_W = 49,
  parameter int DROP_W = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  prl_rx_event_arb_if.slave   bus
);

  localparam logic [1:0] c_SRC_RX = 2'd0;
  localparam logic [1:0] c_SRC_TX = 2'd1;
  localparam logic [1:0] c_SRC_HR = 2'd2;

  logic              r_rx_pend, r_tx_pend, r_hr_pend;
  logic [2:0]        r_rx_result, r_rx_sop, r_tx_result, r_tx_sop, r_hr_sop;
  logic [6:0]        r_rx_type;
  logic [INFO_W-1:0] r_rx_info;
  logic              r_valid;
  logic [1:0]        r_src;
  logic [2:0]        r_result, r_sop;
  logic [6:0]        r_type;
  logic [INFO_W-1:0] r_info;
  logic [DROP_W-1:0] r_drop_cnt;
  logic              r_busy;

  logic              w_rx_pend, w_tx_pend, w_hr_pend;
  logic [2:0]        w_rx_result, w_rx_sop, w_tx_result, w_tx_sop, w_hr_sop;
  logic [6:0]        w_rx_type;
  logic [INFO_W-1:0] w_rx_info;
  logic              w_valid;
  logic [1:0]        w_src;
  logic [2:0]        w_result, w_sop;
  logic [6:0]        w_type;
  logic [INFO_W-1:0] w_info;
  logic [DROP_W-1:0] w_drop_cnt;
  logic              w_busy;

  logic              w_free, w_load_hr, w_load_rx, w_load_tx;
  logic              w_rx_drop, w_tx_drop, w_hr_drop;
  logic [1:0]        w_drop_inc;
  logic [DROP_W+1:0] w_drop_sum;

  // Arbitration only looks at flags held at the start of the cycle; a hard
  // reset in this cycle also blocks RX/TX from moving into the output.
  always_comb begin
    w_free    = !r_valid || bus.pe_evt_ready;
    w_load_hr = w_free && r_hr_pend;
    w_load_rx = w_free && !r_hr_pend && r_rx_pend && !bus.hr_evt_en;
    w_load_tx = w_free && !r_hr_pend && !r_rx_pend && r_tx_pend && !bus.hr_evt_en;

    w_rx_drop = bus.rx_evt_en && !bus.hr_evt_en && r_rx_pend && !w_load_rx;
    w_tx_drop = bus.tx_evt_en && !bus.hr_evt_en && r_tx_pend && !w_load_tx;
    w_hr_drop = bus.hr_evt_en && r_hr_pend && !w_load_hr;
    w_drop_inc = {1'b0, w_rx_drop} + {1'b0, w_tx_drop} + {1'b0, w_hr_drop};
    w_drop_sum = {2'b00, r_drop_cnt} + (DROP_W+2)'(w_drop_inc);
  end

  always_comb begin
    w_rx_pend   = r_rx_pend;
    w_rx_result = r_rx_result;
    w_rx_type   = r_rx_type;
    w_rx_sop    = r_rx_sop;
    w_rx_info   = r_rx_info;
    w_tx_pend   = r_tx_pend;
    w_tx_result = r_tx_result;
    w_tx_sop    = r_tx_sop;
    w_hr_pend   = r_hr_pend;
    w_hr_sop    = r_hr_sop;
    w_valid     = r_valid;
    w_src       = r_src;
    w_result    = r_result;
    w_type      = r_type;
    w_sop       = r_sop;
    w_info      = r_info;
    w_drop_cnt  = r_drop_cnt;

    if (bus.hr_evt_en) begin
      w_rx_pend = 1'b0;
    end else if (bus.rx_evt_en && !w_rx_drop) begin
      w_rx_pend   = 1'b1;
      w_rx_result = bus.rx_evt_result;
      w_rx_type   = bus.rx_evt_type;
      w_rx_sop    = bus.rx_evt_sop;
      w_rx_info   = bus.rx_evt_info;
    end else if (w_load_rx) begin
      w_rx_pend = 1'b0;
    end

    if (bus.hr_evt_en) begin
      w_tx_pend = 1'b0;
    end else if (bus.tx_evt_en && !w_tx_drop) begin
      w_tx_pend   = 1'b1;
      w_tx_result = bus.tx_evt_result;
      w_tx_sop    = bus.tx_evt_sop;
    end else if (w_load_tx) begin
      w_tx_pend = 1'b0;
    end

    if (bus.hr_evt_en && !w_hr_drop) begin
      w_hr_pend = 1'b1;
      w_hr_sop  = bus.hr_evt_sop;
    end else if (w_load_hr) begin
      w_hr_pend = 1'b0;
    end

    if (w_load_hr) begin
      w_valid  = 1'b1;
      w_src    = c_SRC_HR;
      w_result = 3'd0;
      w_type   = 7'd0;
      w_sop    = r_hr_sop;
      w_info   = '0;
    end else if (w_load_rx) begin
      w_valid  = 1'b1;
      w_src    = c_SRC_RX;
      w_result = r_rx_result;
      w_type   = r_rx_type;
      w_sop    = r_rx_sop;
      w_info   = r_rx_info;
    end else if (w_load_tx) begin
      w_valid  = 1'b1;
      w_src    = c_SRC_TX;
      w_result = r_tx_result;
      w_type   = 7'd0;
      w_sop    = r_tx_sop;
      w_info   = '0;
    end else if (w_free) begin
      w_valid = 1'b0;
    end else if (bus.hr_evt_en && r_src != c_SRC_HR) begin
      // A stalled RX/TX entry is stale once a hard reset arrives.
      w_valid = 1'b0;
    end

    if (bus.drop_clr) begin
      w_drop_cnt = '0;
    end else if (w_drop_sum[DROP_W+1:DROP_W] != 2'b00) begin
      w_drop_cnt = '1;
    end else begin
      w_drop_cnt = w_drop_sum[DROP_W-1:0];
    end

    w_busy = w_rx_pend || w_tx_pend || w_hr_pend || w_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_pend   <= 1'b0;
      r_rx_result <= '0;
      r_rx_type   <= '0;
      r_rx_sop    <= '0;
      r_rx_info   <= '0;
      r_tx_pend   <= 1'b0;
      r_tx_result <= '0;
      r_tx_sop    <= '0;
      r_hr_pend   <= 1'b0;
      r_hr_sop    <= '0;
      r_valid     <= 1'b0;
      r_src       <= '0;
      r_result    <= '0;
      r_type      <= '0;
      r_sop       <= '0;
      r_info      <= '0;
      r_drop_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_pend   <= w_rx_pend;
      r_rx_result <= w_rx_result;
      r_rx_type   <= w_rx_type;
      r_rx_sop    <= w_rx_sop;
      r_rx_info   <= w_rx_info;
      r_tx_pend   <= w_tx_pend;
      r_tx_result <= w_tx_result;
      r_tx_sop    <= w_tx_sop;
      r_hr_pend   <= w_hr_pend;
      r_hr_sop    <= w_hr_sop;
      r_valid     <= w_valid;
      r_src       <= w_src;
      r_result    <= w_result;
      r_type      <= w_type;
      r_sop       <= w_sop;
      r_info      <= w_info;
      r_drop_cnt  <= w_drop_cnt;
      r_busy      <= w_busy;
    end
  end

  assign bus.pe_evt_valid  = r_valid;
  assign bus.pe_evt_src    = r_src;
  assign bus.pe_evt_result = r_result;
  assign bus.pe_evt_type   = r_type;
  assign bus.pe_evt_sop    = r_sop;
  assign bus.pe_evt_info   = r_info;
  assign bus.drop_cnt      = r_drop_cnt;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_prl_rx_event_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prl_rx_event_arb                                                        |
// | Directed self-checking bench for prl_rx_event_arb.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_prl_rx_event_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  prl_rx_event_arb_if #(.INFO_W(49), .DROP_W(4)) bus ();

  prl_rx_event_arb #(.INFO_W(49), .DROP_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] src,
                         input logic [2:0] res, input logic [6:0] typ,
                         input logic [2:0] sop, input logic [48:0] info);
    check({tag, ".valid"},  64'(bus.pe_evt_valid),  64'(v));
    check({tag, ".src"},    64'(bus.pe_evt_src),    64'(src));
    check({tag, ".result"}, 64'(bus.pe_evt_result), 64'(res));
    check({tag, ".type"},   64'(bus.pe_evt_type),   64'(typ));
    check({tag, ".sop"},    64'(bus.pe_evt_sop),    64'(sop));
    check({tag, ".info"},   64'(bus.pe_evt_info),   64'(info));
  endtask

  task automatic set_rx(input logic [2:0] res, input logic [6:0] typ,
                        input logic [2:0] sop, input logic [48:0] info);
    bus.rx_evt_en     = 1'b1;
    bus.rx_evt_result = res;
    bus.rx_evt_type   = typ;
    bus.rx_evt_sop    = sop;
    bus.rx_evt_info   = info;
  endtask

  initial begin
    bus.rx_evt_en = 0; bus.rx_evt_result = 0; bus.rx_evt_type = 0;
    bus.rx_evt_sop = 0; bus.rx_evt_info = 0;
    bus.tx_evt_en = 0; bus.tx_evt_result = 0; bus.tx_evt_sop = 0;
    bus.hr_evt_en = 0; bus.hr_evt_sop = 0;
    bus.pe_evt_ready = 0; bus.drop_clr = 0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk_out("rst", 0, 0, 0, 0, 0, 0);
    check("rst.busy", 64'(bus.busy), 64'(0));
    check("rst.drop", 64'(bus.drop_cnt), 64'(0));

    // RX single event
    bus.pe_evt_ready = 1'b1;
    set_rx(3'd1, 7'h41, 3'd0, 49'h1_2345_6789);
    tick();
    bus.rx_evt_en = 1'b0;
    check("rx1.n1.valid", 64'(bus.pe_evt_valid), 64'(0));
    check("rx1.n1.busy", 64'(bus.busy), 64'(1));
    tick();
    chk_out("rx1.n2", 1, 0, 3'd1, 7'h41, 3'd0, 49'h1_2345_6789);
    check("rx1.n2.busy", 64'(bus.busy), 64'(1));
    tick();
    check("rx1.n3.valid", 64'(bus.pe_evt_valid), 64'(0));
    check("rx1.n3.busy", 64'(bus.busy), 64'(0));

    // Priority with hard reset flushing RX/TX
    bus.pe_evt_ready = 1'b0;
    set_rx(3'd2, 7'h22, 3'd1, 49'h55);
    bus.tx_evt_en = 1'b1; bus.tx_evt_result = 3'd5; bus.tx_evt_sop = 3'd1;
    tick();
    bus.rx_evt_en = 1'b0; bus.tx_evt_en = 1'b0;
    bus.hr_evt_en = 1'b1; bus.hr_evt_sop = 3'd3;
    tick();
    bus.hr_evt_en = 1'b0;
    check("pri.n2.valid", 64'(bus.pe_evt_valid), 64'(0));
    bus.pe_evt_ready = 1'b1;
    tick();
    chk_out("pri.n3", 1, 2, 0, 0, 3'd3, 0);
    tick();
    check("pri.n4.valid", 64'(bus.pe_evt_valid), 64'(0));
    check("pri.n4.busy", 64'(bus.busy), 64'(0));
    check("pri.drop", 64'(bus.drop_cnt), 64'(0));

    // Back-pressure and drop
    bus.pe_evt_ready = 1'b0;
    set_rx(3'd3, 7'h0A, 3'd2, 49'hAAAA);
    tick();
    bus.rx_evt_en = 1'b0;
    tick(); tick();
    set_rx(3'd4, 7'h0B, 3'd1, 49'hBBBB);
    tick();
    bus.rx_evt_en = 1'b0;
    tick();
    set_rx(3'd6, 7'h0C, 3'd0, 49'hCCCC);
    tick();
    bus.rx_evt_en = 1'b0;
    check("bp.drop", 64'(bus.drop_cnt), 64'(1));
    chk_out("bp.held", 1, 0, 3'd3, 7'h0A, 3'd2, 49'hAAAA);
    bus.pe_evt_ready = 1'b1;
    tick();
    chk_out("bp.second", 1, 0, 3'd4, 7'h0B, 3'd1, 49'hBBBB);
    tick();
    check("bp.empty", 64'(bus.pe_evt_valid), 64'(0));

    // Hard reset invalidates a stalled RX entry
    bus.pe_evt_ready = 1'b0;
    set_rx(3'd1, 7'h11, 3'd1, 49'h1111);
    tick();
    bus.rx_evt_en = 1'b0;
    tick();
    check("fl.held", 64'(bus.pe_evt_valid), 64'(1));
    bus.hr_evt_en = 1'b1; bus.hr_evt_sop = 3'd2;
    tick();
    bus.hr_evt_en = 1'b0;
    check("fl.gap.valid", 64'(bus.pe_evt_valid), 64'(0));
    check("fl.gap.busy", 64'(bus.busy), 64'(1));
    tick();
    chk_out("fl.hr", 1, 2, 0, 0, 3'd2, 0);
    bus.pe_evt_ready = 1'b1;
    tick();
    check("fl.done", 64'(bus.pe_evt_valid), 64'(0));
    check("fl.drop", 64'(bus.drop_cnt), 64'(1));

    // Saturation and clear: 22 back-to-back RX pulses, first two absorbed
    bus.pe_evt_ready = 1'b0;
    bus.drop_clr = 1'b1;
    tick();
    bus.drop_clr = 1'b0;
    check("sat.clr0", 64'(bus.drop_cnt), 64'(0));
    set_rx(3'd2, 7'h33, 3'd0, 49'h3333);
    for (int i = 0; i < 22; i++) tick();
    check("sat.full", 64'(bus.drop_cnt), 64'(15));
    bus.drop_clr = 1'b1;
    tick();
    bus.drop_clr = 1'b0;
    check("sat.clr", 64'(bus.drop_cnt), 64'(0));
    tick();
    bus.rx_evt_en = 1'b0;
    check("sat.one", 64'(bus.drop_cnt), 64'(1));

    // Reset mid-run with output valid and every slot pending
    bus.hr_evt_en = 1'b1; bus.hr_evt_sop = 3'd4;
    tick();
    bus.hr_evt_en = 1'b0;
    tick();
    bus.hr_evt_en = 1'b1; bus.hr_evt_sop = 3'd5;
    tick();
    bus.hr_evt_en = 1'b0;
    set_rx(3'd7, 7'h7F, 3'd3, 49'h7777);
    bus.tx_evt_en = 1'b1; bus.tx_evt_result = 3'd2; bus.tx_evt_sop = 3'd2;
    tick();
    bus.rx_evt_en = 1'b0; bus.tx_evt_en = 1'b0;
    chk_out("pre.hr", 1, 2, 0, 0, 3'd4, 0);
    check("pre.busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("mrst", 0, 0, 0, 0, 0, 0);
    check("mrst.busy", 64'(bus.busy), 64'(0));
    check("mrst.drop", 64'(bus.drop_cnt), 64'(0));
    tick();
    check("mrst.idle", 64'(bus.pe_evt_valid), 64'(0));
    bus.pe_evt_ready = 1'b1;
    set_rx(3'd5, 7'h05, 3'd1, 49'h5);
    tick();
    bus.rx_evt_en = 1'b0;
    check("post.n1", 64'(bus.pe_evt_valid), 64'(0));
    tick();
    chk_out("post.n2", 1, 0, 3'd5, 7'h05, 3'd1, 49'h5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prl_rx_event_arb.md
# prl_rx_event_arb

Arbitrates and sequences protocol-layer receive-side events toward the policy engine. Three sources compete for a single PE-facing event channel with a valid/ready handshake:
- RX message-received reports
- TX completion reports
- Hard/cable reset indications

Each source has a one-deep pending slot. Hard reset has top priority and flushes stale message events. The block sits between the PRL RX/TX state machines and the PE, and it replaces the PE's fire-and-forget pulse with a back-pressured interface.

## Interface
Parameters:
- INFO_W, 49, width of the RX info snapshot.
- DROP_W, 4, width of the saturating drop counter.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous and active-high, sampled on rising clk.
- rx_evt_en  in  1  one-cycle pulse: RX message report.
- rx_evt_result  in  3  RX result code.
- rx_evt_type  in  7  {message_type[1:0], header_type[4:0]}.
- rx_evt_sop  in  3  SOP type.
- rx_evt_info  in  INFO_W  decoded payload snapshot.
- tx_evt_en  in  1  one-cycle pulse: TX completion report.
- tx_evt_result  in  3  TX result code.
- tx_evt_sop  in  3  SOP type of the transmitted message.
- hr_evt_en  in  1  one-cycle pulse: hard/cable reset received.
- hr_evt_sop  in  3  SOP type of the reset ordered set.
- pe_evt_valid  out  1  event available to the PE.
- pe_evt_ready  in  1  PE accepts the event.
- pe_evt_src  out  2  event source: 0=RX, 1=TX, 2=HR; 3 is never driven.
- pe_evt_result  out  3  result code.
- pe_evt_type  out  7  message type; 0 for TX and HR events.
- pe_evt_sop  out  3  SOP type.
- pe_evt_info  out  INFO_W  RX info; 0 for TX and HR events.
- drop_cnt  out  DROP_W  count of dropped events, saturating.
- drop_clr  in  1  clears drop_cnt.
- busy  out  1  OR of all pending flags and pe_evt_valid.

## Operation
**Pending slots**
- Each source has a pending flag plus captured fields (RX: result, type, sop, info; TX: result, sop; HR: sop).
- A source pulse captures its fields and sets its flag, provided the slot is empty or is being moved to the output register in the same cycle.
- If the slot stays occupied, the new event is dropped, the slot keeps its old contents, and drop_cnt increments.
- Simultaneous drops from several sources increment drop_cnt by 1 per dropped source.
- drop_cnt saturates at all-ones. drop_clr has priority over increments in the same cycle.

**Output register (one entry)**
- "Free" means !pe_evt_valid, or pe_evt_valid & pe_evt_ready.
- When free, it loads the highest-priority pending slot (HR > RX > TX) and clears that flag.
- Only flags already set at the start of the cycle are eligible; pulses in the current cycle are not.

**Hard reset flush**
- When hr_evt_en is seen, the RX and TX pending flags are cleared in the same cycle.
- RX/TX pulses arriving in that same cycle are discarded. Flushed and discarded events do not count as drops.
- If the output register holds an RX or TX event that is not accepted in that cycle, it is invalidated (pe_evt_valid drops next cycle).
- A held HR event is never invalidated. A second HR while the HR slot is full counts as a drop.

**Output field rules**
- TX/HR events drive type=0 and info=0.
- HR events drive result=3'b000.

## Timing
- Reset values:
  - pe_evt_valid=0, pe_evt_src=0, pe_evt_result=0, pe_evt_type=0, pe_evt_sop=0, pe_evt_info=0.
  - drop_cnt=0, busy=0, all pending flags 0.
- Latency: a pulse at cycle N sets pending at N+1. pe_evt_valid rises at N+2 if the output is free at N+1.
- Throughput: with pe_evt_ready held high, one event per cycle.
- Output fields are stable while pe_evt_valid=1 && pe_evt_ready=0.
- pe_evt_valid never drops without acceptance, except on HR flush of an RX/TX entry.
- rst mid-operation: all state clears on the next edge; in-flight and pending events are lost; drop_cnt is not incremented.
- busy is registered, derived from the next-state flags, and valid in the same cycle as the state it reflects.

## Test plan
- **RX single event:** rx_evt_en at N with result=3'd1, type=7'h41, sop=3'd0, info=49'h1_2345_6789, ready=1 -> pe_evt_valid only at N+2 with src=0 and the same fields. busy=1 at N+1..N+2 and 0 at N+3.
- **Priority:** tx_evt_en and rx_evt_en at N, hr_evt_en at N+1, ready=1 from N+3 -> order HR (N+3), then nothing else (RX/TX were flushed). drop_cnt=0.
- **Back-pressure and drop:** ready=0; rx_evt_en at N, N+3, N+5 -> first event held in output, second pending, third dropped, drop_cnt=1. Raise ready -> two events delivered in capture order with unchanged fields.
- **Flush of held output:** RX event valid with ready=0, then hr_evt_en -> pe_evt_valid deasserts one cycle, then the HR event appears with src=2 and type=0.
- **Saturation and clear:** 20 drops -> drop_cnt=4'hF. drop_clr asserted together with a drop -> drop_cnt=0.
- **Reset mid-run:** rst asserted while output valid and all slots pending -> next cycle all outputs 0 and busy=0. The first pulse after reset is delivered 2 cycles later.
